cpu_step_ctrl: RTL and testbench
================================

Name: cpu_step_ctrl

Overview:
- Board-level execution controller between the debounced switch inputs and the pipelined CPU.
- Replaces the free-running divided clock with a single-cycle clock-enable on i_Clk.
- Supports free-run at a slow or fast rate, pause, and single-step per button press.
- Also provides run status and an issued-enable count for the LEDs and the seven-segment display.

Parameters:
- TICK_PERIOD, 25000000, i_Clk cycles between enables in slow run (~1 Hz at 25 MHz); must be ≥2.
- FAST_PERIOD, 2500000, i_Clk cycles between enables when i_Fast=1; must be ≥2 and ≤ TICK_PERIOD.
- CNT_W, 16, width of o_En_Count.

Ports:
- i_Clk  in  1  system clock; single clock domain.
- i_Reset  in  1  synchronous, active-high reset.
- i_Run_Toggle  in  1  debounced level; each rising edge toggles run/pause.
- i_Step  in  1  debounced level; each rising edge requests one enable while paused.
- i_Fast  in  1  level; 1 selects FAST_PERIOD, 0 selects TICK_PERIOD.
- o_Cpu_En  out  1  one-cycle clock-enable pulse to the CPU pipeline.
- o_Running  out  1  1 in RUNNING state.
- o_Heartbeat  out  1  toggles on every o_Cpu_En pulse.
- o_En_Count  out  CNT_W  total enables issued; wraps.

Behaviour:
- Reset values: state RUNNING, o_Cpu_En=0, o_Running=1, o_Heartbeat=0, o_En_Count=0, prescaler=0.
- Edge-detect "previous" registers reset to 1. A switch held through reset produces no edge on release of reset.
- Rising edge: input=1 and previous=0 in cycle n. The resulting action is registered, so it is visible at n+1.
- States: RUNNING, PAUSED.
- Run edge in RUNNING: go to PAUSED. Prescaler is cleared; no enable is issued in that cycle even if the prescaler was at terminal count.
- Run edge in PAUSED: go to RUNNING with the prescaler cleared. The first run-mode enable comes period cycles later.
- RUNNING prescaler:
  - Counts 0..P-1, where P is selected by the current i_Fast.
  - When prescaler ≥ P-1, it wraps to 0 and o_Cpu_En=1 for exactly one cycle.
  - The ≥ comparison covers i_Fast switching mid-count to a shorter period: the enable occurs on the next cycle, never a lost wrap.
- PAUSED:
  - Prescaler is held at 0.
  - Step edge gives o_Cpu_En=1 on the next cycle, for exactly one cycle.
  - Step held high gives no further pulses.
- Step edges in RUNNING are ignored.
- Simultaneous run edge and step edge while PAUSED: the step enable is issued and the state goes to RUNNING with the prescaler cleared.
- Simultaneous run edge and terminal count while RUNNING: the pause wins and no enable is issued.
- Every o_Cpu_En pulse increments o_En_Count (modulo 2^CNT_W, all-ones wraps to 0) and toggles o_Heartbeat in the same cycle the pulse is asserted.
- o_Cpu_En is never high on two consecutive cycles.
- i_Reset mid-operation: all state returns to reset values on the next edge, and any pending enable is dropped.
- Prescaler width is $clog2(TICK_PERIOD). All outputs are registered.
- Integration: CPU registers update only when o_Cpu_En=1; clk_div and slow_clk are removed from the top level.

Decomposition:
- Shared package (cpu_ctrl_pkg):
  - run-state enum {RUNNING, PAUSED};
  - default period constants for the 25 MHz board clock.
- One sub-module, rise_edge_detect: a previous-value register with a reset value of 1, producing a one-cycle rise pulse. It is instantiated twice (run, step).

Test Plan (TICK_PERIOD=8, FAST_PERIOD=3, CNT_W=4):
- Release reset, all inputs 0 → o_Running=1; o_Cpu_En pulses on cycles 8, 16, 24 after reset release; o_En_Count=3; o_Heartbeat=1.
- Hold i_Run_Toggle=1 through reset, then release → no state change, o_Running stays 1. A later 0→1 sets o_Running=0 the next cycle, and no enable follows for 20 cycles.
- Paused, pulse i_Step high for 5 cycles → exactly one o_Cpu_En, one cycle after the rise. Repeat 17 times → o_En_Count wraps to 1.
- Running at prescaler=5 with i_Fast=0, raise i_Fast → enable on the next cycle, then every 3 cycles.
- Paused, raise i_Run_Toggle and i_Step in the same cycle → one enable the next cycle and o_Running=1. The next enable comes 8 cycles after the transition.
- Running, run edge coincides with terminal count → no enable; o_Running=0; o_En_Count unchanged. Assert i_Reset mid-count → all outputs return to reset values.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared run-state type and default period constants for the 25 MHz board clock.
package cpu_ctrl_pkg;
    typedef enum logic {RUNNING, PAUSED} run_state_t;
    localparam int DEF_TICK_PERIOD = 25000000;
    localparam int DEF_FAST_PERIOD = 2500000;
    localparam int DEF_CNT_W       = 16;
endpackage

// File: rtl/cpu_step_ctrl_if.sv
// cpu_step_ctrl_if: switch inputs and CPU/display outputs of the step controller.
// Ports: i_Run_Toggle, i_Step, i_Fast (switch side); o_Cpu_En, o_Running, o_Heartbeat, o_En_Count.
// master drives the switches and observes the outputs; slave is the controller.
interface cpu_step_ctrl_if import cpu_ctrl_pkg::*; #(
    parameter int CNT_W = DEF_CNT_W
);
    logic             i_Run_Toggle;
    logic             i_Step;
    logic             i_Fast;
    logic             o_Cpu_En;
    logic             o_Running;
    logic             o_Heartbeat;
    logic [CNT_W-1:0] o_En_Count;
    modport master (
        output i_Run_Toggle, i_Step, i_Fast,
        input  o_Cpu_En, o_Running, o_Heartbeat, o_En_Count
    );
    modport slave (
        input  i_Run_Toggle, i_Step, i_Fast,
        output o_Cpu_En, o_Running, o_Heartbeat, o_En_Count
    );
endinterface

// File: rtl/rise_edge_detect.sv
// rise_edge_detect: one-cycle pulse on a 0->1 transition of a debounced level.
// Ports: i_Clk, i_Reset (sync, active-high), i_D level in, o_Rise pulse out.
// The previous value resets to 1 so a switch held through reset gives no edge.
module rise_edge_detect (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_D,
    output logic o_Rise
);
    logic r_prev;
    always_ff @(posedge i_Clk) begin
        if (i_Reset) r_prev <= 1'b1;
        else         r_prev <= i_D;
    end
    assign o_Rise = i_D & ~r_prev;
endmodule

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: single-cycle CPU clock-enable generator with slow/fast run, pause and single-step.
// Ports: i_Clk, i_Reset (sync, active-high), bus (cpu_step_ctrl_if.slave): switch levels in,
// o_Cpu_En pulse, o_Running status, o_Heartbeat toggle and o_En_Count enable count out.
module cpu_step_ctrl import cpu_ctrl_pkg::*; #(
    parameter int TICK_PERIOD = DEF_TICK_PERIOD,
    parameter int FAST_PERIOD = DEF_FAST_PERIOD,
    parameter int CNT_W       = DEF_CNT_W
) (
    input logic            i_Clk,
    input logic            i_Reset,
    cpu_step_ctrl_if.slave bus
);
    localparam int PW = $clog2(TICK_PERIOD);
    logic             w_run_rise, w_step_rise, w_en_n;
    run_state_t       r_state, w_state_n;
    logic [PW-1:0]    r_presc, w_presc_n;
    logic             r_cpu_en, r_running, r_heartbeat;
    logic [CNT_W-1:0] r_en_count;
    int               w_last;

    rise_edge_detect u_run  (.i_Clk(i_Clk), .i_Reset(i_Reset), .i_D(bus.i_Run_Toggle), .o_Rise(w_run_rise));
    rise_edge_detect u_step (.i_Clk(i_Clk), .i_Reset(i_Reset), .i_D(bus.i_Step),       .o_Rise(w_step_rise));

    assign w_last = (bus.i_Fast ? FAST_PERIOD : TICK_PERIOD) - 1;

    // >= rather than == so a switch to the shorter period mid-count fires next cycle.
    // A run edge in RUNNING pauses and suppresses a coinciding terminal-count enable.
    always_comb begin
        w_state_n = r_state;
        w_presc_n = r_presc;
        w_en_n    = 1'b0;
        if (r_state == RUNNING) begin
            if (w_run_rise) begin
                w_state_n = PAUSED;
                w_presc_n = '0;
            end else if (int'(r_presc) >= w_last) begin
                w_presc_n = '0;
                w_en_n    = 1'b1;
            end else begin
                w_presc_n = r_presc + PW'(1);
            end
        end else begin
            w_presc_n = '0;
            w_en_n    = w_step_rise;
            w_state_n = w_run_rise ? RUNNING : PAUSED;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state     <= RUNNING;
            r_presc     <= '0;
            r_cpu_en    <= 1'b0;
            r_running   <= 1'b1;
            r_heartbeat <= 1'b0;
            r_en_count  <= '0;
        end else begin
            r_state   <= w_state_n;
            r_presc   <= w_presc_n;
            r_cpu_en  <= w_en_n;
            r_running <= (w_state_n == RUNNING);
            if (w_en_n) begin
                r_heartbeat <= ~r_heartbeat;
                r_en_count  <= r_en_count + CNT_W'(1);
            end
        end
    end

    assign bus.o_Cpu_En    = r_cpu_en;
    assign bus.o_Running   = r_running;
    assign bus.o_Heartbeat = r_heartbeat;
    assign bus.o_En_Count  = r_en_count;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: directed and randomized checks of cpu_step_ctrl against a cycle-elapsed reference model.
module tb_cpu_step_ctrl;
    localparam int TP = 8;
    localparam int FP = 3;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    cpu_step_ctrl_if #(.CNT_W(CW)) bus ();
    cpu_step_ctrl #(.TICK_PERIOD(TP), .FAST_PERIOD(FP), .CNT_W(CW)) dut (
        .i_Clk(clk), .i_Reset(rst), .bus(bus)
    );

    // Reference model: running flag, cycles elapsed since the last enable or restart,
    // last seen switch levels, and the visible outputs.
    bit m_run, m_pr, m_ps, m_en, m_hb;
    int m_elapsed, m_cnt;

    // Advances the model with the inputs present before the edge, then moves past the edge.
    task automatic tick();
        bit rr, sr, fire;
        int p;
        if (rst) begin
            m_run = 1; m_elapsed = 0; m_pr = 1; m_ps = 1; m_en = 0; m_hb = 0; m_cnt = 0;
        end else begin
            rr = bus.i_Run_Toggle && !m_pr;
            sr = bus.i_Step && !m_ps;
            p = bus.i_Fast ? FP : TP;
            fire = 0;
            if (m_run && rr) begin
                m_run = 0; m_elapsed = 0;
            end else if (m_run) begin
                m_elapsed++;
                if (m_elapsed >= p) begin fire = 1; m_elapsed = 0; end
            end else begin
                fire = sr; m_elapsed = 0; m_run = rr;
            end
            m_pr = bus.i_Run_Toggle;
            m_ps = bus.i_Step;
            m_en = fire;
            if (fire) begin m_hb = !m_hb; m_cnt = (m_cnt + 1) % (1 << CW); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        bus.i_Run_Toggle = 0; bus.i_Step = 0; bus.i_Fast = 0;
        tick(); tick();
        checks++;
        if ({bus.o_Cpu_En, bus.o_Running, bus.o_Heartbeat, bus.o_En_Count} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL reset_values got en=%b run=%b hb=%b cnt=%0d want 0 1 0 0",
                     bus.o_Cpu_En, bus.o_Running, bus.o_Heartbeat, bus.o_En_Count);
        end
    endtask

    task automatic test_free_run();
        rst = 0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            checks++;
            if (bus.o_Cpu_En !== (i % 8 == 0)) begin
                errors++;
                $display("FAIL free_run_en cycle=%0d got %b want %b", i, bus.o_Cpu_En, (i % 8 == 0));
            end
        end
        checks++;
        if ({bus.o_Running, bus.o_Heartbeat, bus.o_En_Count} !== {1'b1, 1'b1, 4'd3}) begin
            errors++;
            $display("FAIL free_run_final got run=%b hb=%b cnt=%0d want 1 1 3",
                     bus.o_Running, bus.o_Heartbeat, bus.o_En_Count);
        end
    endtask

    task automatic test_held_toggle();
        bus.i_Run_Toggle = 1;
        rst = 1; tick(); tick();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.o_Running !== 1'b1) begin
                errors++;
                $display("FAIL held_toggle_run cycle=%0d got %b want 1", i, bus.o_Running);
            end
        end
        bus.i_Run_Toggle = 0; tick();
        bus.i_Run_Toggle = 1; tick();
        checks++;
        if (bus.o_Running !== 1'b0) begin
            errors++;
            $display("FAIL toggle_pause got %b want 0", bus.o_Running);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (bus.o_Cpu_En !== 1'b0) begin
                errors++;
                $display("FAIL paused_no_en cycle=%0d got %b want 0", i, bus.o_Cpu_En);
            end
        end
    endtask

    task automatic test_step_wrap();
        for (int r = 0; r < 17; r++) begin
            bus.i_Step = 1;
            for (int c = 0; c < 5; c++) begin
                tick();
                checks++;
                if (bus.o_Cpu_En !== (c == 0)) begin
                    errors++;
                    $display("FAIL step_pulse rep=%0d cyc=%0d got %b want %b", r, c, bus.o_Cpu_En, (c == 0));
                end
            end
            bus.i_Step = 0; tick(); tick();
        end
        checks++;
        if ({bus.o_Running, bus.o_Heartbeat, bus.o_En_Count} !== {1'b0, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL step_wrap got run=%b hb=%b cnt=%0d want 0 1 1",
                     bus.o_Running, bus.o_Heartbeat, bus.o_En_Count);
        end
    endtask

    task automatic test_fast_switch();
        bus.i_Run_Toggle = 0; tick();
        bus.i_Run_Toggle = 1; tick();
        checks++;
        if (bus.o_Running !== 1'b1) begin
            errors++;
            $display("FAIL resume_run got %b want 1", bus.o_Running);
        end
        bus.i_Run_Toggle = 0;
        for (int i = 0; i < 5; i++) tick();
        bus.i_Fast = 1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (bus.o_Cpu_En !== (k % 3 == 1)) begin
                errors++;
                $display("FAIL fast_switch k=%0d got %b want %b", k, bus.o_Cpu_En, (k % 3 == 1));
            end
        end
        checks++;
        if (bus.o_En_Count !== 4'd5) begin
            errors++;
            $display("FAIL fast_count got %0d want 5", bus.o_En_Count);
        end
    endtask

    task automatic test_simultaneous();
        bus.i_Fast = 0;
        bus.i_Run_Toggle = 1; tick();
        bus.i_Run_Toggle = 0; tick();
        checks++;
        if (bus.o_Running !== 1'b0) begin
            errors++;
            $display("FAIL simul_pause got %b want 0", bus.o_Running);
        end
        bus.i_Run_Toggle = 1; bus.i_Step = 1; tick();
        checks++;
        if ({bus.o_Cpu_En, bus.o_Running, bus.o_En_Count} !== {1'b1, 1'b1, 4'd6}) begin
            errors++;
            $display("FAIL simul_edge got en=%b run=%b cnt=%0d want 1 1 6",
                     bus.o_Cpu_En, bus.o_Running, bus.o_En_Count);
        end
        bus.i_Run_Toggle = 0; bus.i_Step = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (bus.o_Cpu_En !== (k == 8)) begin
                errors++;
                $display("FAIL simul_next k=%0d got %b want %b", k, bus.o_Cpu_En, (k == 8));
            end
        end
    endtask

    task automatic test_pause_terminal();
        for (int i = 0; i < 7; i++) tick();
        bus.i_Run_Toggle = 1; tick();
        checks++;
        if ({bus.o_Cpu_En, bus.o_Running, bus.o_Heartbeat, bus.o_En_Count} !== {1'b0, 1'b0, 1'b1, 4'd7}) begin
            errors++;
            $display("FAIL pause_terminal got en=%b run=%b hb=%b cnt=%0d want 0 0 1 7",
                     bus.o_Cpu_En, bus.o_Running, bus.o_Heartbeat, bus.o_En_Count);
        end
        bus.i_Run_Toggle = 0; tick();
        bus.i_Run_Toggle = 1; tick();
        bus.i_Run_Toggle = 0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1; tick();
        checks++;
        if ({bus.o_Cpu_En, bus.o_Running, bus.o_Heartbeat, bus.o_En_Count} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL mid_reset got en=%b run=%b hb=%b cnt=%0d want 0 1 0 0",
                     bus.o_Cpu_En, bus.o_Running, bus.o_Heartbeat, bus.o_En_Count);
        end
        rst = 0;
    endtask

    task automatic test_random();
        bit last_en = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0)  bus.i_Run_Toggle = !bus.i_Run_Toggle;
            if ($urandom_range(0, 2) == 0)  bus.i_Step = !bus.i_Step;
            if ($urandom_range(0, 19) == 0) bus.i_Fast = !bus.i_Fast;
            rst = ($urandom_range(0, 149) == 0);
            tick();
            checks++;
            if ({bus.o_Cpu_En, bus.o_Running, bus.o_Heartbeat, bus.o_En_Count} !== {m_en, m_run, m_hb, m_cnt[CW-1:0]}) begin
                errors++;
                $display("FAIL random cycle=%0d got en=%b run=%b hb=%b cnt=%0d want %b %b %b %0d", i,
                         bus.o_Cpu_En, bus.o_Running, bus.o_Heartbeat, bus.o_En_Count, m_en, m_run, m_hb, m_cnt);
            end
            checks++;
            if (last_en && bus.o_Cpu_En) begin
                errors++;
                $display("FAIL en_back_to_back cycle=%0d got 1 want 0", i);
            end
            last_en = bus.o_Cpu_En;
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_held_toggle();
        test_step_wrap();
        test_fast_switch();
        test_simultaneous();
        test_pause_terminal();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
